adc_dual_capture: RTL and testbench

Dual serial-ADC capture engine for the WAC board. Drives chip-select and serial clock for the two 12-bit ADCs (16-clock frames: 4 leading zeros, then 12 data bits MSB first) and deserialises both SDO lines in parallel. Delivers 12-bit sample pairs with a one-cycle ready strobe to the control/communication layer, which writes them into BRAM port B. Runs single-shot or fixed-length bursts.

---
 rtl/adc_dual_capture.sv | 183 ++++++++++++++++++
 tb/tb_adc_dual_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dual_capture.sv
// adc_dual_capture: drives CS/SCLK for two 12-bit serial ADCs sharing one
// timing engine, deserialises both SDO lines and delivers sample pairs
// singly or in fixed-length bursts.
module adc_dual_capture #(
    parameter int HALF_DIV = 2,  // clk cycles per SCLK half-period
    parameter int QUIET    = 4   // CS-high gap between burst frames
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adc_en,
    input  logic        start,
    input  logic        mode_adc,
    input  logic [11:0] n_samples,
    input  logic        sdo_adc1,
    input  logic        sdo_adc2,
    output logic        cs_adc1,
    output logic        cs_adc2,
    output logic        clk_adc1,
    output logic        clk_adc2,
    output logic [11:0] data_adc1,
    output logic [11:0] data_adc2,
    output logic        ready_adc,
    output logic        busy,
    output logic        done,
    output logic [11:0] sample_cnt,
    output logic        frame_err
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_LATCH, S_QUIET} state_t;

    localparam int            CW     = 16;
    localparam logic [CW-1:0] HD     = CW'(HALF_DIV);
    localparam logic [CW-1:0] HD_M1  = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] HD2_M1 = CW'(2 * HALF_DIV - 1);
    localparam logic [CW-1:0] QT     = CW'(QUIET);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_n;
    logic          go, go_n;       // start accepted, frame begins next cycle
    logic          mode_q;
    logic [11:0]   nsamp_q;
    logic [11:0]   sr1, sr2;
    logic          cs_q, sclk_q, cs_n, sclk_n;
    logic          accept, zero_done, sample_en, latch_en, last;

    assign accept    = (state == S_IDLE) && !go && adc_en && start;
    assign zero_done = (state == S_IDLE) && go && adc_en && mode_q && (nsamp_q == 12'd0);
    // the cycle that ends the low phase: SCLK rises on this edge
    assign sample_en = adc_en && (state == S_SHIFT) && (cnt == HD_M1);
    assign latch_en  = adc_en && (state == S_LATCH);
    assign last      = !mode_q || (sample_cnt + 12'd1 == nsamp_q);

    assign cs_adc1  = cs_q;
    assign cs_adc2  = cs_q;
    assign clk_adc1 = sclk_q;
    assign clk_adc2 = sclk_q;

    // next-state logic; pin levels are derived from the next state so the
    // registered CS/SCLK always match the state they belong to
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        go_n    = go;
        if (!adc_en) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            go_n    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        go_n = 1'b0;
                        if (!zero_done) begin
                            state_n = S_SETUP;
                            cnt_n   = '0;
                        end
                    end else if (accept) begin
                        go_n = 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == HD_M1) begin
                        state_n = S_SHIFT;
                        cnt_n   = '0;
                        bit_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == HD2_M1) begin
                        cnt_n = '0;
                        if (bit_idx == 4'd15) state_n = S_LATCH;
                        else                  bit_n   = bit_idx + 4'd1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    cnt_n   = '0;
                    state_n = last ? S_IDLE : S_QUIET;
                end
                // QUIET+1 cycles: the extra one matches the start-acceptance
                // cycle so every frame in a burst has the same start-to-ready time
                S_QUIET: begin
                    if (cnt == QT) begin
                        state_n = S_SETUP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        cs_n   = !((state_n == S_SETUP) || (state_n == S_SHIFT));
        sclk_n = !((state_n == S_SHIFT) && (cnt_n < HD));
    end

    // state register and registered ADC pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 4'd0;
            go      <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            go      <= go_n;
            cs_q    <= cs_n;
            sclk_q  <= sclk_n;
        end
    end

    // capture datapath, delivery strobes, counters and status
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            nsamp_q    <= 12'd0;
            sr1        <= 12'd0;
            sr2        <= 12'd0;
            data_adc1  <= 12'd0;
            data_adc2  <= 12'd0;
            ready_adc  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            sample_cnt <= 12'd0;
            frame_err  <= 1'b0;
        end else begin
            ready_adc <= 1'b0;
            done      <= 1'b0;
            if (accept) begin
                mode_q     <= mode_adc;
                nsamp_q    <= n_samples;
                sample_cnt <= 12'd0;
                frame_err  <= 1'b0;
                busy       <= 1'b1;
            end
            if (sample_en) begin
                sr1 <= {sr1[10:0], sdo_adc1};
                sr2 <= {sr2[10:0], sdo_adc2};
                // first four bits of each frame must be zero
                if ((bit_idx < 4'd4) && (sdo_adc1 || sdo_adc2)) frame_err <= 1'b1;
            end
            if (latch_en) begin
                data_adc1  <= sr1;
                data_adc2  <= sr2;
                ready_adc  <= 1'b1;
                sample_cnt <= sample_cnt + 12'd1;
                if (last) done <= 1'b1;
            end
            if (zero_done) done <= 1'b1;
            if (!adc_en || ((state == S_IDLE) && !go && !accept)) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_dual_capture.sv
// Directed bench for adc_dual_capture: a default build (HALF_DIV=2, QUIET=4)
// with a behavioural dual-ADC model, plus a HALF_DIV=1, QUIET=1 build for timing.
module tb_adc_dual_capture;

    logic        clk = 1'b0;
    logic        rst, adc_en, start, start_b, mode_adc;
    logic [11:0] n_samples;
    logic        sdo1 = 1'b0, sdo2 = 1'b0;
    logic        sdo_b = 1'b0;

    logic        cs1_a, cs2_a, sclk1_a, sclk2_a, ready_a, busy_a, done_a, ferr_a;
    logic [11:0] d1_a, d2_a, cnt_a;
    logic        cs1_b, cs2_b, sclk1_b, sclk2_b, ready_b, busy_b, done_b, ferr_b;
    logic [11:0] d1_b, d2_b, cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_dual_capture #(.HALF_DIV(2), .QUIET(4)) dut_a (
        .clk(clk), .rst(rst), .adc_en(adc_en), .start(start), .mode_adc(mode_adc),
        .n_samples(n_samples), .sdo_adc1(sdo1), .sdo_adc2(sdo2),
        .cs_adc1(cs1_a), .cs_adc2(cs2_a), .clk_adc1(sclk1_a), .clk_adc2(sclk2_a),
        .data_adc1(d1_a), .data_adc2(d2_a), .ready_adc(ready_a), .busy(busy_a),
        .done(done_a), .sample_cnt(cnt_a), .frame_err(ferr_a));

    adc_dual_capture #(.HALF_DIV(1), .QUIET(1)) dut_b (
        .clk(clk), .rst(rst), .adc_en(adc_en), .start(start_b), .mode_adc(mode_adc),
        .n_samples(n_samples), .sdo_adc1(sdo_b), .sdo_adc2(sdo_b),
        .cs_adc1(cs1_b), .cs_adc2(cs2_b), .clk_adc1(sclk1_b), .clk_adc2(sclk2_b),
        .data_adc1(d1_b), .data_adc2(d2_b), .ready_adc(ready_b), .busy(busy_b),
        .done(done_b), .sample_cnt(cnt_b), .frame_err(ferr_b));

    // ADC model: frame words come from mem[frame - base]; a new bit is driven
    // on every SCLK fall while CS is low, MSB first
    logic [15:0] mem1 [16];
    logic [15:0] mem2 [16];
    int nfall = 0, seen = 0, base = 0, bidx = 15;

    always @(negedge cs1_a) nfall++;

    always @(negedge sclk1_a) begin
        if (!cs1_a) begin
            if (seen != nfall) begin
                seen = nfall;
                bidx = 15;
            end
            sdo1 = mem1[(nfall - 1 - base) & 15][bidx];
            sdo2 = mem2[(nfall - 1 - base) & 15][bidx];
            bidx--;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse start for one edge; returns at the negedge after the sampling edge
    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else     start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    // count edges until ready is seen; optionally re-pulse start at cycle poke
    task automatic wait_ready(input bit sel, input int poke,
                              output int cyc, output int csl, output int hi);
        cyc = 0; csl = -1; hi = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == poke);
            if ((sel ? cs1_b : cs1_a) == 1'b0 && csl < 0) csl = cyc;
            if ((sel ? cs1_b : cs1_a) == 1'b1 && csl < 0) hi++;
        end while (!(sel ? ready_b : ready_a) && cyc < 400);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pins"}, {28'd0, cs1_a, cs2_a, sclk1_a, sclk2_a}, 32'hF);
        chk({tag, "_flags"}, {28'd0, ready_a, busy_a, done_a, ferr_a}, 32'h0);
        chk({tag, "_data"}, {8'd0, d1_a, d2_a}, 32'h0);
        chk({tag, "_cnt"}, {20'd0, cnt_a}, 32'h0);
    endtask

    initial begin
        int lat, csl, hi, dcyc, lowc, rises, nrdy;
        logic prev;
        rst = 1'b1; adc_en = 1'b1; start = 1'b0; start_b = 1'b0;
        mode_adc = 1'b0; n_samples = 12'd0;
        for (int i = 0; i < 16; i++) begin mem1[i] = 16'h0; mem2[i] = 16'h0; end
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // single conversion
        mem1[0] = 16'h0ABC; mem2[0] = 16'h0123; base = nfall; mode_adc = 1'b0;
        pulse(0);
        wait_ready(0, -1, lat, csl, hi);
        chk("single_lat", lat, 68);
        chk("single_cslow", csl, 1);
        chk("single_d1", {20'd0, d1_a}, 32'hABC);
        chk("single_d2", {20'd0, d2_a}, 32'h123);
        chk("single_done", {31'd0, done_a}, 1);
        chk("single_busy", {31'd0, busy_a}, 1);
        chk("single_cnt", {20'd0, cnt_a}, 1);
        chk("single_ferr", {31'd0, ferr_a}, 0);
        @(posedge clk); @(negedge clk);
        chk("single_after", {29'd0, busy_a, ready_a, done_a}, 0);

        // burst of 5; n_samples changed after start and a stray start mid-frame 2
        for (int k = 0; k < 5; k++) begin
            mem1[k] = 16'(k + 1); mem2[k] = 16'((k + 1) * 16);
        end
        base = nfall; mode_adc = 1'b1; n_samples = 12'd5;
        pulse(0);
        n_samples = 12'd2;
        for (int k = 1; k <= 5; k++) begin
            wait_ready(0, (k == 2) ? 30 : -1, lat, csl, hi);
            chk($sformatf("burst_lat%0d", k), lat, (k == 1) ? 68 : 72);
            chk($sformatf("burst_d1_%0d", k), {20'd0, d1_a}, k);
            chk($sformatf("burst_d2_%0d", k), {20'd0, d2_a}, k * 16);
            chk($sformatf("burst_done%0d", k), {31'd0, done_a}, (k == 5) ? 1 : 0);
            chk($sformatf("burst_cnt%0d", k), {20'd0, cnt_a}, k);
            if (k > 1) chk($sformatf("burst_csgap%0d", k), {31'd0, (hi + 2 >= 5)}, 1);
        end
        @(posedge clk); @(negedge clk);
        chk("burst_busy_end", {31'd0, busy_a}, 0);

        // zero-length burst
        mode_adc = 1'b1; n_samples = 12'd0; dcyc = -1; lowc = 0;
        pulse(0);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (done_a && dcyc < 0) dcyc = i;
            if (!cs1_a) lowc++;
            if (i == 1) chk("zero_busy1", {31'd0, busy_a}, 1);
        end
        chk("zero_done_cyc", dcyc, 1);
        chk("zero_cs_low", lowc, 0);
        chk("zero_busy_end", {31'd0, busy_a}, 0);
        chk("zero_cnt", {20'd0, cnt_a}, 0);

        // frame error on ADC1 leading bit, sticky, cleared by next start
        mem1[0] = 16'h8FFF; mem2[0] = 16'h0555; base = nfall; mode_adc = 1'b0;
        pulse(0);
        wait_ready(0, -1, lat, csl, hi);
        chk("ferr_d1", {20'd0, d1_a}, 32'hFFF);
        chk("ferr_d2", {20'd0, d2_a}, 32'h555);
        chk("ferr_set", {31'd0, ferr_a}, 1);
        repeat (20) @(negedge clk);
        chk("ferr_sticky", {31'd0, ferr_a}, 1);
        mem1[0] = 16'h0111; mem2[0] = 16'h1234; base = nfall;
        pulse(0);
        chk("ferr_clear", {31'd0, ferr_a}, 0);
        wait_ready(0, -1, lat, csl, hi);
        chk("ferr2_d2", {20'd0, d2_a}, 32'h234);
        chk("ferr2_bit4", {31'd0, ferr_a}, 1);

        // abort in bit 9 of frame 3 of a 10-sample burst
        for (int k = 0; k < 10; k++) begin
            mem1[k] = 16'h0101 + 16'(k); mem2[k] = 16'h0201 + 16'(k);
        end
        base = nfall; mode_adc = 1'b1; n_samples = 12'd10;
        pulse(0);
        wait_ready(0, -1, lat, csl, hi);
        chk("abort_lat1", lat, 68);
        wait_ready(0, -1, lat, csl, hi);
        chk("abort_lat2", lat, 72);
        rises = 0; prev = sclk1_a;
        for (int i = 0; i < 300 && rises < 9; i++) begin
            @(posedge clk); @(negedge clk);
            if (sclk1_a && !prev && !cs1_a) rises++;
            prev = sclk1_a;
        end
        chk("abort_reach_bit9", rises, 9);
        adc_en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort_pins", {29'd0, cs1_a, sclk1_a, busy_a}, 32'b110);
        nrdy = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); @(negedge clk);
            if (ready_a || done_a) nrdy++;
        end
        chk("abort_no_strobe", nrdy, 0);
        chk("abort_cnt", {20'd0, cnt_a}, 2);
        chk("abort_d1", {20'd0, d1_a}, 32'h102);
        chk("abort_d2", {20'd0, d2_a}, 32'h202);
        adc_en = 1'b1;
        mem1[0] = 16'h0777; mem2[0] = 16'h0888; base = nfall; mode_adc = 1'b0;
        pulse(0);
        wait_ready(0, -1, lat, csl, hi);
        chk("post_abort_lat", lat, 68);
        chk("post_abort_d1", {20'd0, d1_a}, 32'h777);
        chk("post_abort_cnt", {20'd0, cnt_a}, 1);
        chk("post_abort_done", {31'd0, done_a}, 1);

        // reset mid-SHIFT
        base = nfall;
        pulse(0);
        repeat (30) @(negedge clk);
        chk("mid_cs_low", {31'd0, cs1_a}, 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;

        // fast build: HALF_DIV=1, QUIET=1
        mode_adc = 1'b1; n_samples = 12'd2;
        pulse(1);
        wait_ready(1, -1, lat, csl, hi);
        chk("fast_lat", lat, 35);
        chk("fast_cslow", csl, 1);
        wait_ready(1, -1, lat, csl, hi);
        chk("fast_period", lat, 36);
        chk("fast_done", {31'd0, done_b}, 1);
        chk("fast_cnt", {20'd0, cnt_b}, 2);
        chk("fast_data", {8'd0, d1_b, d2_b}, 0);
        chk("fast_flags", {27'd0, cs1_b, cs2_b, sclk1_b, sclk2_b, ferr_b}, 32'b11110);
        @(posedge clk); @(negedge clk);
        chk("fast_busy_end", {31'd0, busy_b}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
